// File: rtl/dac_frame_scheduler.sv
// Round-robin arbiter sharing one serial DAC link between NUM_CH sample sources.
// Each granted request is sent as an {address, sample} frame, MSB first, under an active-low LOAD_SHIFT strobe.
module dac_frame_scheduler #(
   parameter int NUM_CH   = 4,
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int SCLK_DIV = 1,
   parameter int GAP_CYC  = 2
) (
   input  logic                       CLKOUT,
   input  logic                       RESET,
   input  logic [NUM_CH-1:0]          REQ,
   input  logic [NUM_CH*DATA_W-1:0]   WDATA,
   output logic [NUM_CH-1:0]          ACK,
   output logic                       BUSY,
   output logic                       SCLK,
   output logic                       LOAD_SHIFT,
   output logic                       DI
);

   localparam int FRAME_BITS = ADDR_W + DATA_W;
   localparam int PTR_W      = $clog2(NUM_CH);
   localparam int BIT_W      = $clog2(FRAME_BITS);
   localparam int DIV_W      = $clog2(SCLK_DIV + 1);
   localparam int GAP_W      = $clog2(GAP_CYC + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

   state_t                  r_state, w_state;
   logic [PTR_W-1:0]        r_ptr, w_ptr;
   logic [FRAME_BITS-1:0]   r_shift, w_shift;
   logic [BIT_W-1:0]        r_bit, w_bit;
   logic [DIV_W-1:0]        r_div, w_div;
   logic [GAP_W-1:0]        r_gap, w_gap;
   logic [NUM_CH-1:0]       r_ack, w_ack;
   logic                    r_busy, w_busy;
   logic                    r_sclk, w_sclk;
   logic                    r_ls, w_ls;
   logic                    r_di, w_di;
   logic                    w_found;
   logic [PTR_W-1:0]        w_win;
   logic [PTR_W-1:0]        w_cand;

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         w_cand = PTR_W'((32'(r_ptr) + 32'd1 + i) % NUM_CH);
         if (!w_found && REQ[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   always_comb begin
      w_state = r_state;
      w_ptr   = r_ptr;
      w_shift = r_shift;
      w_bit   = r_bit;
      w_div   = r_div;
      w_gap   = r_gap;
      w_ack   = '0;
      w_busy  = r_busy;
      w_sclk  = r_sclk;
      w_ls    = r_ls;
      w_di    = r_di;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_ack[w_win] = 1'b1;
               w_shift      = {ADDR_W'(w_win), WDATA[w_win*DATA_W +: DATA_W]};
               w_ptr        = w_win;
               w_state      = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // LOAD_SHIFT still high marks the ACK cycle: open the frame with bit 0's low phase
            if (r_ls) begin
               w_ls   = 1'b0;
               w_busy = 1'b1;
               w_sclk = 1'b0;
               w_di   = r_shift[FRAME_BITS-1];
               w_div  = '0;
               w_bit  = '0;
            end else if (r_div != DIV_W'(SCLK_DIV - 1)) begin
               w_div = r_div + 1'b1;
            end else begin
               w_div = '0;
               if (!r_sclk) begin
                  w_sclk = 1'b1;
               end else if (r_bit == BIT_W'(FRAME_BITS - 1)) begin
                  w_state = ST_GAP;
                  w_ls    = 1'b1;
                  w_sclk  = 1'b0;
                  w_di    = 1'b1;
                  w_gap   = '0;
               end else begin
                  w_bit   = r_bit + 1'b1;
                  w_sclk  = 1'b0;
                  w_shift = {r_shift[FRAME_BITS-2:0], 1'b0};
                  w_di    = r_shift[FRAME_BITS-2];
               end
            end
         end
         ST_GAP: begin
            if (r_gap == GAP_W'(GAP_CYC - 1)) begin
               w_state = ST_IDLE;
               w_busy  = 1'b0;
            end else begin
               w_gap = r_gap + 1'b1;
            end
         end
         default: w_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLKOUT or posedge RESET) begin
      if (RESET) begin
         r_state <= ST_IDLE;
         r_ptr   <= PTR_W'(NUM_CH - 1);
         r_shift <= '0;
         r_bit   <= '0;
         r_div   <= '0;
         r_gap   <= '0;
         r_ack   <= '0;
         r_busy  <= 1'b0;
         r_sclk  <= 1'b0;
         r_ls    <= 1'b1;
         r_di    <= 1'b1;
      end else begin
         r_state <= w_state;
         r_ptr   <= w_ptr;
         r_shift <= w_shift;
         r_bit   <= w_bit;
         r_div   <= w_div;
         r_gap   <= w_gap;
         r_ack   <= w_ack;
         r_busy  <= w_busy;
         r_sclk  <= w_sclk;
         r_ls    <= w_ls;
         r_di    <= w_di;
      end
   end

   assign ACK        = r_ack;
   assign BUSY       = r_busy;
   assign SCLK       = r_sclk;
   assign LOAD_SHIFT = r_ls;
   assign DI         = r_di;

endmodule
